// File: rtl/fp_pkg.sv
// Shared single-precision constants and pipeline payload types for the FP add/sub unit.
package fp_pkg;

    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_BIAS = 127;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP_PINF = 32'h7F80_0000;

    localparam int FLAG_INV = 3;
    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_NX  = 0;

    // Working significand: hidden bit, mantissa, then guard/round/sticky.
    localparam int SIG_W = MAN_W + 4;

    typedef struct packed {
        logic             valid;
        logic [4:0]       fd;
        logic             sign;
        logic [EXP_W-1:0] expo;
        logic             effSub;
        logic [SIG_W-1:0] sigBig;
        logic [SIG_W-1:0] sigSml;
        logic             negZero;
        logic             specValid;
        logic             specInvalid;
        logic [31:0]      specResult;
    } align_t;

    typedef struct packed {
        logic             valid;
        logic [4:0]       fd;
        logic             sign;
        logic [EXP_W-1:0] expo;
        logic [SIG_W:0]   total;
        logic [4:0]       lzc;
        logic             negZero;
        logic             specValid;
        logic             specInvalid;
        logic [31:0]      specResult;
    } sum_t;

endpackage

// File: rtl/fp_lzc28.sv
// Combinational leading-zero counter for the 28-bit significand sum (28 when all zero).
module fp_lzc28 (
    input  logic [27:0] value_i,
    output logic [4:0]  count_o
);

    // Ascending scan so the most significant set bit is the last to write.
    always_comb begin
        count_o = 5'd28;
        for (int i = 0; i < 28; i++) begin
            if (value_i[i]) begin
                count_o = 5'(27 - i);
            end
        end
    end

endmodule

// File: rtl/fp_add_s.sv
// Three-stage pipelined single-precision add.s/sub.s: align, add + LZC, normalize/round/pack.
module fp_add_s
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic        in_sub,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [4:0]  in_fd,
    output logic        out_valid,
    output logic [31:0] out_result,
    output logic [4:0]  out_fd,
    output logic [3:0]  out_flags,
    output logic        busy
);

    align_t align_d, align_q;
    sum_t   sum_d, sum_q;

    logic        outValid_q;
    logic [31:0] result_d, result_q;
    logic [4:0]  fd_q;
    logic [3:0]  flags_d, flags_q;

    // ---------------- Stage 1: unpack / align ----------------
    logic             signA, signB, zeroA, zeroB, infA, infB, nanA, nanB, swap;
    logic [EXP_W-1:0] expA, expB, bigExp, smlExp, shiftAmt;
    logic [MAN_W-1:0] manA, manB;
    logic [SIG_W-1:0] bigSig, smlSig, shifted, lostMask, smlAligned;
    logic             specValid, specInvalid;
    logic [31:0]      specResult;

    assign signA = in_a[31];
    assign signB = in_b[31] ^ in_sub;
    assign expA  = in_a[30:23];
    assign expB  = in_b[30:23];
    assign zeroA = (expA == '0);
    assign zeroB = (expB == '0);
    assign manA  = zeroA ? '0 : in_a[MAN_W-1:0];
    assign manB  = zeroB ? '0 : in_b[MAN_W-1:0];
    assign infA  = (expA == '1) && (in_a[MAN_W-1:0] == '0);
    assign infB  = (expB == '1) && (in_b[MAN_W-1:0] == '0);
    assign nanA  = (expA == '1) && (in_a[MAN_W-1:0] != '0);
    assign nanB  = (expB == '1) && (in_b[MAN_W-1:0] != '0);

    assign swap     = {expB, manB} > {expA, manA};
    assign bigExp   = swap ? expB : expA;
    assign smlExp   = swap ? expA : expB;
    assign bigSig   = swap ? {~zeroB, manB, 3'b000} : {~zeroA, manA, 3'b000};
    assign smlSig   = swap ? {~zeroA, manA, 3'b000} : {~zeroB, manB, 3'b000};
    assign shiftAmt = bigExp - smlExp;
    assign shifted  = smlSig >> shiftAmt;
    assign lostMask = (SIG_W'(1) << shiftAmt) - SIG_W'(1);

    always_comb begin
        if (shiftAmt >= 8'd26) begin
            smlAligned = {{(SIG_W-1){1'b0}}, |smlSig};
        end else begin
            smlAligned = {shifted[SIG_W-1:1], shifted[0] | (|(smlSig & lostMask))};
        end
    end

    always_comb begin
        specValid   = 1'b0;
        specInvalid = 1'b0;
        specResult  = '0;
        if (nanA || nanB || (infA && infB && (signA != signB))) begin
            specValid   = 1'b1;
            specInvalid = 1'b1;
            specResult  = FP_QNAN;
        end else if (infA) begin
            specValid  = 1'b1;
            specResult = FP_PINF | {signA, 31'b0};
        end else if (infB) begin
            specValid  = 1'b1;
            specResult = FP_PINF | {signB, 31'b0};
        end
    end

    always_comb begin
        align_d.valid       = in_valid;
        align_d.fd          = in_fd;
        align_d.sign        = swap ? signB : signA;
        align_d.expo        = bigExp;
        align_d.effSub      = signA ^ signB;
        align_d.sigBig      = bigSig;
        align_d.sigSml      = smlAligned;
        align_d.negZero     = zeroA & zeroB & signA & signB;
        align_d.specValid   = specValid;
        align_d.specInvalid = specInvalid;
        align_d.specResult  = specResult;
    end

    // ---------------- Stage 2: significand add + LZC ----------------
    logic [SIG_W:0] sumRaw;
    logic [4:0]     sumLzc;

    assign sumRaw = align_q.effSub ? ({1'b0, align_q.sigBig} - {1'b0, align_q.sigSml})
                                   : ({1'b0, align_q.sigBig} + {1'b0, align_q.sigSml});

    fp_lzc28 u_lzc (
        .value_i (sumRaw),
        .count_o (sumLzc)
    );

    always_comb begin
        sum_d.valid       = align_q.valid;
        sum_d.fd          = align_q.fd;
        sum_d.sign        = align_q.sign;
        sum_d.expo        = align_q.expo;
        sum_d.total       = sumRaw;
        sum_d.lzc         = sumLzc;
        sum_d.negZero     = align_q.negZero;
        sum_d.specValid   = align_q.specValid;
        sum_d.specInvalid = align_q.specInvalid;
        sum_d.specResult  = align_q.specResult;
    end

    // ---------------- Stage 3: normalize / round / pack ----------------
    // Shifting by the LZC puts the leading one at bit 27 (dropped); a carry-out
    // has LZC 0, so its bit 0 folds into sticky exactly like a right shift by 1.
    logic [SIG_W-1:0]  norm;
    logic              guardB, roundB, stickyB, roundUp, inexact;
    logic [MAN_W:0]    fracSum;
    logic signed [9:0] expN, expR;

    assign norm    = SIG_W'(sum_q.total << sum_q.lzc);
    assign guardB  = norm[3];
    assign roundB  = norm[2];
    assign stickyB = |norm[1:0];
    assign inexact = guardB | roundB | stickyB;
    assign roundUp = guardB & (roundB | stickyB | norm[4]);
    assign fracSum = {1'b0, norm[SIG_W-1:4]} + {{MAN_W{1'b0}}, roundUp};
    assign expN    = $signed({2'b00, sum_q.expo}) + 10'sd1 - $signed({5'b00000, sum_q.lzc});
    assign expR    = expN + $signed({9'b0, fracSum[MAN_W]});

    always_comb begin
        result_d          = {sum_q.sign, expR[EXP_W-1:0], fracSum[MAN_W-1:0]};
        flags_d           = '0;
        flags_d[FLAG_NX]  = inexact;
        if (sum_q.specValid) begin
            result_d          = sum_q.specResult;
            flags_d           = '0;
            flags_d[FLAG_INV] = sum_q.specInvalid;
        end else if (sum_q.total == '0) begin
            result_d = {sum_q.negZero, 31'b0};
            flags_d  = '0;
        end else if (expR >= 10'sd255) begin
            result_d          = FP_PINF | {sum_q.sign, 31'b0};
            flags_d[FLAG_OVF] = 1'b1;
            flags_d[FLAG_NX]  = 1'b1;
        end else if (expR <= 10'sd0) begin
            result_d          = {sum_q.sign, 31'b0};
            flags_d[FLAG_UNF] = 1'b1;
            flags_d[FLAG_NX]  = 1'b1;
        end
    end

    // Flush is applied after the stall hold so it always clears the valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            align_q    <= '0;
            sum_q      <= '0;
            outValid_q <= 1'b0;
            result_q   <= '0;
            fd_q       <= '0;
            flags_q    <= '0;
        end else begin
            if (!stall) begin
                align_q    <= align_d;
                sum_q      <= sum_d;
                outValid_q <= sum_q.valid;
                result_q   <= result_d;
                fd_q       <= sum_q.fd;
                flags_q    <= flags_d;
            end
            if (flush) begin
                align_q.valid <= 1'b0;
                sum_q.valid   <= 1'b0;
                outValid_q    <= 1'b0;
            end
        end
    end

    assign out_valid  = outValid_q;
    assign out_result = result_q;
    assign out_fd     = fd_q;
    assign out_flags  = flags_q;
    assign busy       = align_q.valid | sum_q.valid | outValid_q;

endmodule

// File: tb/tb_fp_add_s.sv
// Directed self-checking bench for fp_add_s: arithmetic cases, stall/flush streams, async reset.
module tb_fp_add_s;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        in_sub;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_fd;
    logic        out_valid;
    logic [31:0] out_result;
    logic [4:0]  out_fd;
    logic [3:0]  out_flags;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Stream operands: 1.0 + {1,2,3,4} gives {2,3,4,5}.
    logic [31:0] streamB   [4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
    logic [31:0] streamRes [4] = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};

    fp_add_s dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_sub     (in_sub),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_fd      (in_fd),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_fd     (out_fd),
        .out_flags  (out_flags),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic sub, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] fd);
        in_valid = valid;
        in_sub   = sub;
        in_a     = a;
        in_b     = b;
        in_fd    = fd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic runOp(input string tag, input logic sub, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] fd, input logic [31:0] expRes, input logic [3:0] expFlags);
        applyStimulus(1'b1, sub, a, b, fd);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        checkOutput({tag, " valid@1"}, {31'b0, out_valid}, 32'd0);
        tick();
        checkOutput({tag, " valid@2"}, {31'b0, out_valid}, 32'd0);
        tick();
        checkOutput({tag, " valid@3"}, {31'b0, out_valid}, 32'd1);
        checkOutput({tag, " result"}, out_result, expRes);
        checkOutput({tag, " flags"}, {28'b0, out_flags}, {28'b0, expFlags});
        checkOutput({tag, " fd"}, {27'b0, out_fd}, {27'b0, fd});
    endtask

    // Issues 1.0 + streamB[k] with fd k+1 on every unstalled cycle; expects fds firstFd..4 in order.
    task automatic streamTest(input string tag, input int stallAt, input int flushAt, input int firstFd);
        int idx = 0;
        int nxt = firstFd - 1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            stall = (cyc == stallAt) || (cyc == stallAt + 1);
            flush = (cyc == flushAt);
            if (idx < 4) begin
                applyStimulus(1'b1, 1'b0, 32'h3F80_0000, streamB[idx], 5'(idx + 1));
            end else begin
                applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
            end
            if (out_valid) begin
                if (nxt < 4) begin
                    checkOutput({tag, " fd"}, {27'b0, out_fd}, 32'(nxt + 1));
                    checkOutput({tag, " result"}, out_result, streamRes[nxt]);
                end else begin
                    checkOutput({tag, " extra valid"}, {31'b0, out_valid}, 32'd0);
                end
                if (!stall) nxt++;
            end
            tick();
            if (!stall && in_valid) idx++;
        end
        stall = 1'b0;
        flush = 1'b0;
        checkOutput({tag, " count"}, 32'(nxt), 32'd4);
        checkOutput({tag, " busy idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        #2;
        checkOutput("reset valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset busy", {31'b0, busy}, 32'd0);
        checkOutput("reset result", out_result, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        $display("[TB] arithmetic vectors");
        runOp("1.5+2.25",  1'b0, 32'h3FC0_0000, 32'h4010_0000, 5'd5,  32'h4070_0000, 4'b0000);
        runOp("1-1",       1'b1, 32'h3F80_0000, 32'h3F80_0000, 5'd6,  32'h0000_0000, 4'b0000);
        runOp("-0+-0",     1'b0, 32'h8000_0000, 32'h8000_0000, 5'd7,  32'h8000_0000, 4'b0000);
        runOp("inf-inf",   1'b1, 32'h7F80_0000, 32'h7F80_0000, 5'd8,  32'h7FC0_0000, 4'b1000);
        runOp("max+max",   1'b0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 5'd9,  32'h7F80_0000, 4'b0101);
        runOp("tie even",  1'b0, 32'h3F80_0000, 32'h3380_0000, 5'd10, 32'h3F80_0000, 4'b0001);
        runOp("tie odd",   1'b0, 32'h3F80_0001, 32'h3380_0000, 5'd11, 32'h3F80_0002, 4'b0001);
        runOp("nan+1",     1'b0, 32'h7F80_0001, 32'h3F80_0000, 5'd12, 32'h7FC0_0000, 4'b1000);
        runOp("inf+1",     1'b0, 32'h7F80_0000, 32'h3F80_0000, 5'd13, 32'h7F80_0000, 4'b0000);
        runOp("1-2",       1'b1, 32'h3F80_0000, 32'h4000_0000, 5'd14, 32'hBF80_0000, 4'b0000);
        runOp("denorm+1",  1'b0, 32'h0000_0001, 32'h3F80_0000, 5'd15, 32'h3F80_0000, 4'b0000);
        runOp("far shift", 1'b0, 32'h3F80_0000, 32'h3200_0000, 5'd16, 32'h3F80_0000, 4'b0001);
        runOp("underflow", 1'b1, 32'h0080_0000, 32'h0080_0001, 5'd17, 32'h8000_0000, 4'b0011);
        tick();
        checkOutput("pulse end", {31'b0, out_valid}, 32'd0);

        $display("[TB] stall and flush streams");
        streamTest("stall", 3, -1, 1);
        streamTest("flush", -10, 2, 4);

        $display("[TB] asynchronous reset mid-flight");
        applyStimulus(1'b1, 1'b0, 32'h3F80_0000, 32'h3F80_0000, 5'd20);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h3F80_0000, 32'h4000_0000, 5'd21);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h3F80_0000, 32'h4040_0000, 5'd22);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        checkOutput("pre-reset valid", {31'b0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async valid", {31'b0, out_valid}, 32'd0);
        checkOutput("async busy", {31'b0, busy}, 32'd0);
        checkOutput("async result", out_result, 32'h0);
        checkOutput("async fd", {27'b0, out_fd}, 32'd0);
        checkOutput("async flags", {28'b0, out_flags}, 32'd0);
        #1 rst_n = 1'b1;
        tick();
        checkOutput("post-reset busy", {31'b0, busy}, 32'd0);
        runOp("1+1", 1'b0, 32'h3F80_0000, 32'h3F80_0000, 5'd23, 32'h4000_0000, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
